multicycle_controller: RTL

Control unit for the multicycle RV32I core. It holds the instruction-sequencing FSM and the main and ALU decoders. It drives the datapath select and write strobes, including `immsrc_o`, which steers the immediate extender for the instruction held in the instruction register. It takes opcode and function fields from the instruction register and `zero_i` from the ALU. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.

---
 rtl/multicycle_controller.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle RV32I core: instruction-sequencing FSM plus
// main decoder, immediate-format decoder and ALU decoder.
module multicycle_controller (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  output logic [1:0] immsrc_o,
  output logic       pcwrite_o,
  output logic       adrsrc_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic [1:0] resultsrc_o,
  output logic [1:0] alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic       regwrite_o,
  output logic [2:0] alucontrol_o
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state_q, state_d, out_state;
  logic [1:0] aluop;
  logic       pcupdate, branch;
  logic       irwrite_raw, regwrite_raw, memwrite_raw;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // While reset is held the outputs present FETCH with every strobe gated off,
  // even if the state register still holds an abandoned instruction's state.
  always_comb begin
    out_state    = rst_i ? S_FETCH : state_q;
    adrsrc_o     = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    resultsrc_o  = 2'b00;
    alusrca_o    = 2'b00;
    alusrcb_o    = 2'b00;
    aluop        = 2'b00;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    case (out_state)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        alusrcb_o   = 2'b10;
        resultsrc_o = 2'b10;
        pcupdate    = 1'b1;
      end
      S_DECODE: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b01;
      end
      S_MEMADR: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
      end
      S_MEMREAD: adrsrc_o = 1'b1;
      S_MEMWB: begin
        resultsrc_o  = 2'b01;
        regwrite_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_o     = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECR: begin
        alusrca_o = 2'b10;
        aluop     = 2'b10;
      end
      S_EXECI: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
        aluop     = 2'b10;
      end
      S_ALUWB: regwrite_raw = 1'b1;
      S_BEQ: begin
        alusrca_o = 2'b10;
        aluop     = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b10;
        pcupdate  = 1'b1;
      end
      default: ;
    endcase
    pcwrite_o  = ~rst_i & (pcupdate | (branch & zero_i));
    irwrite_o  = ~rst_i & irwrite_raw;
    regwrite_o = ~rst_i & regwrite_raw;
    memwrite_o = ~rst_i & memwrite_raw;
  end

  always_comb begin
    case (op_i)
      OP_SW:   immsrc_o = 2'b01;
      OP_BEQ:  immsrc_o = 2'b10;
      OP_JAL:  immsrc_o = 2'b11;
      default: immsrc_o = 2'b00;
    endcase
  end

  // funct7b5 only selects sub for R-type; addi shares funct3 000 with add/sub.
  always_comb begin
    alucontrol_o = 3'b000;
    case (aluop)
      2'b01: alucontrol_o = 3'b001;
      2'b10: begin
        case (funct3_i)
          3'b000:  alucontrol_o = (op_i[5] & funct7b5_i) ? 3'b001 : 3'b000;
          3'b010:  alucontrol_o = 3'b101;
          3'b110:  alucontrol_o = 3'b011;
          3'b111:  alucontrol_o = 3'b010;
          default: alucontrol_o = 3'b000;
        endcase
      end
      default: alucontrol_o = 3'b000;
    endcase
  end

endmodule
